// File: rtl/solver_pkg.sv
// Shared DPLL solver types: variable state encoding, trace entry types and
// the backtrack controller state set.
package solver_pkg;

  localparam int VAR_W_DEFAULT = 9;

  typedef enum logic [1:0] {
    VS_UNASSIGNED = 2'b00,
    VS_FALSE      = 2'b01,
    VS_TRUE       = 2'b10
  } var_state_t;

  localparam logic TT_DECISION = 1'b0;
  localparam logic TT_FORCED   = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    FLIP  = 3'd2,
    DONE  = 3'd3,
    UNSAT = 3'd4
  } bt_state_t;

endpackage

// File: rtl/backtrack_ctrl_if.sv
// Trace table access bus: top-of-stack view plus push/pop strobes.
interface backtrack_ctrl_if #(
  parameter int VAR_W = 9
);
  logic             tt_empty;
  logic             tt_type_out;
  logic             tt_val_out;
  logic [VAR_W-1:0] tt_variable_out;
  logic             tt_push;
  logic             tt_pop;
  logic             tt_t_type;
  logic             tt_val;
  logic [VAR_W-1:0] tt_variable;

  // Controller side: drives strobes and the pushed entry, observes the top entry.
  modport master (
    input  tt_empty, tt_type_out, tt_val_out, tt_variable_out,
    output tt_push, tt_pop, tt_t_type, tt_val, tt_variable
  );

  // Trace table side.
  modport slave (
    output tt_empty, tt_type_out, tt_val_out, tt_variable_out,
    input  tt_push, tt_pop, tt_t_type, tt_val, tt_variable
  );
endinterface

// File: rtl/backtrack_ctrl.sv
// Backtrack controller: on a conflict, unwinds forced trace entries
// (unassigning their variables) down to the latest decision, then re-pushes
// that decision as a forced entry with the opposite value. An empty trace
// with no decision left means the formula is unsatisfiable.
module backtrack_ctrl
  import solver_pkg::*;
#(
  parameter int VAR_W = VAR_W_DEFAULT,
  parameter int CNT_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conflict,
  backtrack_ctrl_if.master  tt,
  output logic              var_wr_en,
  output logic [VAR_W-1:0]  var_wr_idx,
  output var_state_t        var_wr_val,
  output logic              busy,
  output logic              bt_done,
  output logic              unsat,
  output logic [CNT_W-1:0]  undone_cnt
);

  bt_state_t        state_r;
  logic [VAR_W-1:0] flip_var_r;
  logic             flip_val_r;
  logic [CNT_W-1:0] cnt_r;

  assign busy       = (state_r != IDLE) && (state_r != UNSAT);
  assign bt_done    = (state_r == DONE);
  assign unsat      = (state_r == UNSAT);
  assign undone_cnt = cnt_r;

  // Strobes and write port decoded from state and the current top entry.
  always_comb begin
    tt.tt_push     = 1'b0;
    tt.tt_pop      = 1'b0;
    tt.tt_t_type   = 1'b0;
    tt.tt_val      = 1'b0;
    tt.tt_variable = {VAR_W{1'b0}};
    var_wr_en      = 1'b0;
    var_wr_idx     = {VAR_W{1'b0}};
    var_wr_val     = VS_UNASSIGNED;
    case (state_r)
      CHECK: begin
        if (!tt.tt_empty) begin
          tt.tt_pop = 1'b1;
          if (tt.tt_type_out == TT_FORCED) begin
            var_wr_en  = 1'b1;
            var_wr_idx = tt.tt_variable_out;
            var_wr_val = VS_UNASSIGNED;
          end else begin
            var_wr_en  = 1'b0;
          end
        end else begin
          tt.tt_pop = 1'b0;
        end
      end
      FLIP: begin
        tt.tt_push     = 1'b1;
        tt.tt_t_type   = TT_FORCED;
        tt.tt_val      = flip_val_r;
        tt.tt_variable = flip_var_r;
        var_wr_en      = 1'b1;
        var_wr_idx     = flip_var_r;
        var_wr_val     = flip_val_r ? VS_TRUE : VS_FALSE;
      end
      default: begin
        tt.tt_push = 1'b0;
      end
    endcase
  end

  // State sequencing, decision latch and saturating undone-entry counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      flip_var_r <= {VAR_W{1'b0}};
      flip_val_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (conflict) begin
            state_r <= CHECK;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        CHECK: begin
          if (tt.tt_empty) begin
            state_r <= UNSAT;
          end else begin
            if (cnt_r != {CNT_W{1'b1}}) begin
              cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (tt.tt_type_out == TT_DECISION) begin
              flip_var_r <= tt.tt_variable_out;
              flip_val_r <= ~tt.tt_val_out;
              state_r    <= FLIP;
            end
          end
        end
        FLIP:    state_r <= DONE;
        DONE:    state_r <= IDLE;
        UNSAT:   state_r <= UNSAT;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Table-driven bench for backtrack_ctrl with a small behavioural trace table.
module tb_backtrack_ctrl;
  import solver_pkg::*;

  localparam int VW = 9;
  localparam int CW = 10;
  localparam int NV = 36;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic conflict = 1'b0;
  logic var_wr_en, busy, bt_done, unsat;
  logic [VW-1:0] var_wr_idx;
  var_state_t var_wr_val;
  logic [CW-1:0] undone_cnt;

  backtrack_ctrl_if #(.VAR_W(VW)) tt_bus ();

  backtrack_ctrl #(.VAR_W(VW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .conflict(conflict), .tt(tt_bus),
    .var_wr_en(var_wr_en), .var_wr_idx(var_wr_idx), .var_wr_val(var_wr_val),
    .busy(busy), .bt_done(bt_done), .unsat(unsat), .undone_cnt(undone_cnt)
  );

  always #5 clk = ~clk;

  // Trace table model
  logic          st_type [0:15];
  logic          st_val  [0:15];
  logic [VW-1:0] st_var  [0:15];
  int sp = 0;
  int proto_err = 0;
  logic ld_en = 1'b0, ld_type = 1'b0, ld_val = 1'b0;
  logic [VW-1:0] ld_var = '0;

  assign tt_bus.tt_empty        = (sp == 0);
  assign tt_bus.tt_type_out     = (sp > 0) ? st_type[sp-1] : 1'b0;
  assign tt_bus.tt_val_out      = (sp > 0) ? st_val[sp-1]  : 1'b0;
  assign tt_bus.tt_variable_out = (sp > 0) ? st_var[sp-1]  : '0;

  always @(posedge clk) begin
    if (reset) begin
      sp <= 0;
    end else begin
      if (tt_bus.tt_push && tt_bus.tt_pop) proto_err <= proto_err + 1;
      if (tt_bus.tt_pop && sp == 0) proto_err <= proto_err + 1;
      if (tt_bus.tt_pop) begin
        if (sp > 0) sp <= sp - 1;
      end else if (tt_bus.tt_push && sp < 16) begin
        st_type[sp] <= tt_bus.tt_t_type;
        st_val[sp]  <= tt_bus.tt_val;
        st_var[sp]  <= tt_bus.tt_variable;
        sp <= sp + 1;
      end else if (ld_en && sp < 16) begin
        st_type[sp] <= ld_type;
        st_val[sp]  <= ld_val;
        st_var[sp]  <= ld_var;
        sp <= sp + 1;
      end
    end
  end

  // Expected-output vector: {pop,push,t_type,tt_val,tt_var,wr_en,wr_idx,wr_val,busy,done,unsat,cnt}
  typedef struct packed {
    logic        rst;
    logic        conflict;
    logic [37:0] exp;
  } vec_t;

  vec_t vt [0:NV-1];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input int r, input int c, input int pop, input int push,
                              input int tty, input int tv, input int tvar, input int we,
                              input int widx, input int wval, input int bsy, input int dn,
                              input int us, input int cnt);
    vec_t v;
    v.rst = 1'(r);
    v.conflict = 1'(c);
    v.exp = {1'(pop), 1'(push), 1'(tty), 1'(tv), 9'(tvar), 1'(we), 9'(widx),
             2'(wval), 1'(bsy), 1'(dn), 1'(us), 10'(cnt)};
    return v;
  endfunction

  task automatic run_vec(input int lo, input int hi);
    logic [37:0] act;
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      reset = vt[i].rst;
      conflict = vt[i].conflict;
      #1;
      act = {tt_bus.tt_pop, tt_bus.tt_push, tt_bus.tt_t_type, tt_bus.tt_val,
             tt_bus.tt_variable, var_wr_en, var_wr_idx, var_wr_val, busy,
             bt_done, unsat, undone_cnt};
      checks++;
      if (act !== vt[i].exp) begin
        errors++;
        $display("FAIL vec[%0d]: got %h expected %h", i, act, vt[i].exp);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    conflict = 1'b0;
  endtask

  task automatic load(input logic ty, input logic v, input int x);
    @(negedge clk);
    ld_en = 1'b1; ld_type = ty; ld_val = v; ld_var = VW'(x);
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    conflict = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_stack(input string nm, input int n, input logic ty,
                             input logic v, input int x);
    checks++;
    if (sp != n || (n > 0 && (tt_bus.tt_type_out !== ty || tt_bus.tt_val_out !== v ||
                              tt_bus.tt_variable_out !== VW'(x)))) begin
      errors++;
      $display("FAIL %s: depth %0d top t=%b v=%b var=%0d, expected depth %0d top t=%b v=%b var=%0d",
               nm, sp, tt_bus.tt_type_out, tt_bus.tt_val_out, tt_bus.tt_variable_out,
               n, ty, v, x);
    end
  endtask

  initial begin
    // A: reset with conflict asserted, then idle
    vt[0]  = mk(1,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[1]  = mk(1,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[2]  = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[3]  = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    // B: {D x5=1, F x7=0, F x9=1}
    vt[4]  = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[5]  = mk(0,0, 1,0,0,0,0, 1,9,0, 1,0,0, 0);
    vt[6]  = mk(0,0, 1,0,0,0,0, 1,7,0, 1,0,0, 1);
    vt[7]  = mk(0,0, 1,0,0,0,0, 0,0,0, 1,0,0, 2);
    vt[8]  = mk(0,0, 0,1,1,0,5, 1,5,1, 1,0,0, 3);
    vt[9]  = mk(0,0, 0,0,0,0,0, 0,0,0, 1,1,0, 3);
    vt[10] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 3);
    // C: {D x1=0, F x2=1}, conflict re-pulsed in CHECK and DONE
    vt[11] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[12] = mk(0,0, 1,0,0,0,0, 1,2,0, 1,0,0, 0);
    vt[13] = mk(0,1, 1,0,0,0,0, 0,0,0, 1,0,0, 1);
    vt[14] = mk(0,0, 0,1,1,1,1, 1,1,2, 1,0,0, 2);
    vt[15] = mk(0,1, 0,0,0,0,0, 0,0,0, 1,1,0, 2);
    vt[16] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 2);
    vt[17] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 2);
    // D: empty stack
    vt[18] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[19] = mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0);
    vt[20] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,1, 0);
    vt[21] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,1, 0);
    // E: {F x3=1, F x4=0}, no decision
    vt[22] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[23] = mk(0,0, 1,0,0,0,0, 1,4,0, 1,0,0, 0);
    vt[24] = mk(0,0, 1,0,0,0,0, 1,3,0, 1,0,0, 1);
    vt[25] = mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 2);
    vt[26] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,1, 2);
    vt[27] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,1, 2);
    vt[28] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,1, 2);
    // F: {D x8=1, F x6=1, F x2=0}, reset after one pop
    vt[29] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[30] = mk(0,0, 1,0,0,0,0, 1,2,0, 1,0,0, 0);
    vt[31] = mk(1,0, 1,0,0,0,0, 1,6,0, 1,0,0, 1);
    vt[32] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[33] = mk(0,1, 0,0,0,0,0, 0,0,0, 0,0,0, 0);
    vt[34] = mk(0,0, 0,0,0,0,0, 0,0,0, 1,0,0, 0);
    vt[35] = mk(0,0, 0,0,0,0,0, 0,0,0, 0,0,1, 0);

    run_vec(0, 3);

    load(TT_DECISION, 1'b1, 5);
    load(TT_FORCED, 1'b0, 7);
    load(TT_FORCED, 1'b1, 9);
    run_vec(4, 10);
    check_stack("flip_stack_b", 1, TT_FORCED, 1'b0, 5);

    do_reset();
    load(TT_DECISION, 1'b0, 1);
    load(TT_FORCED, 1'b1, 2);
    run_vec(11, 17);
    check_stack("flip_stack_c", 1, TT_FORCED, 1'b1, 1);

    do_reset();
    run_vec(18, 21);
    check_stack("empty_stack_d", 0, 1'b0, 1'b0, 0);

    do_reset();
    load(TT_FORCED, 1'b1, 3);
    load(TT_FORCED, 1'b0, 4);
    run_vec(22, 28);
    check_stack("drained_stack_e", 0, 1'b0, 1'b0, 0);

    do_reset();
    load(TT_DECISION, 1'b1, 8);
    load(TT_FORCED, 1'b1, 6);
    load(TT_FORCED, 1'b0, 2);
    run_vec(29, 35);

    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL tt_protocol: %0d violations, expected 0", proto_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
